// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg : shared FFT widths, sample/twiddle types and S3 round/saturate.
// Macro FFT_TW_SAT_EN selects clamping (defined) or two's-complement wrap.
// Rev 1.0
// ============================================================================
package fft_pkg;

   localparam int DW      = 9;
   localparam int TW_W    = 10;
   localparam int TW_FRAC = 8;
   localparam int PW      = DW + TW_W;
   localparam int SW      = PW + 1;
   localparam int RW      = SW + 1;

   localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [TW_W-1:0] re;
      logic signed [TW_W-1:0] im;
   } tw_t;

   // Extra guard bit keeps the rounding add from overflowing before the shift.
   function automatic logic signed [DW-1:0] sat_round(input logic signed [SW-1:0] s);
      logic signed [RW-1:0] t;
      t = (RW'(s) + RW'(2 ** (TW_FRAC - 1))) >>> TW_FRAC;
`ifdef FFT_TW_SAT_EN
      if (t > RW'(S_MAX))
         return S_MAX;
      else if (t < RW'(S_MIN))
         return S_MIN;
      else
         return t[DW-1:0];
`else
      return t[DW-1:0];
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_cmul.sv
`default_nettype none
// ============================================================================
// fft_cmul : two-stage complex multiply (products, then add/sub + round/sat).
// Rounding/saturation behaviour follows FFT_TW_SAT_EN via fft_pkg::sat_round.
// Rev 1.0
// ============================================================================
module fft_cmul
   import fft_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_en,
   input  logic                   i_valid,
   input  logic signed [DW-1:0]   i_x_re,
   input  logic signed [DW-1:0]   i_x_im,
   input  logic signed [TW_W-1:0] i_w_re,
   input  logic signed [TW_W-1:0] i_w_im,
   input  logic [1:0]             i_idx,
   output logic                   o_valid,
   output logic signed [DW-1:0]   o_y_re,
   output logic signed [DW-1:0]   o_y_im,
   output logic [1:0]             o_idx
);

   logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
   logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
   logic [1:0]           idx2_q, idx2_d, idx3_q, idx3_d;
   logic                 v2_q, v2_d, v3_q, v3_d;
   cplx_t                y_q, y_d;
   logic signed [SW-1:0] w_sr, w_si;

   assign w_sr = SW'(rr_q) - SW'(ii_q);
   assign w_si = SW'(ri_q) + SW'(ir_q);

   always_comb begin
      rr_d   = rr_q;
      ii_d   = ii_q;
      ri_d   = ri_q;
      ir_d   = ir_q;
      idx2_d = idx2_q;
      v2_d   = v2_q;
      y_d    = y_q;
      idx3_d = idx3_q;
      v3_d   = v3_q;
      if (i_en) begin
         rr_d   = PW'(i_x_re) * PW'(i_w_re);
         ii_d   = PW'(i_x_im) * PW'(i_w_im);
         ri_d   = PW'(i_x_re) * PW'(i_w_im);
         ir_d   = PW'(i_x_im) * PW'(i_w_re);
         idx2_d = i_idx;
         v2_d   = i_valid;
         y_d.re = sat_round(w_sr);
         y_d.im = sat_round(w_si);
         idx3_d = idx2_q;
         v3_d   = v2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q   <= '0;
         ii_q   <= '0;
         ri_q   <= '0;
         ir_q   <= '0;
         idx2_q <= '0;
         v2_q   <= 1'b0;
         y_q    <= '0;
         idx3_q <= '0;
         v3_q   <= 1'b0;
      end else begin
         rr_q   <= rr_d;
         ii_q   <= ii_d;
         ri_q   <= ri_d;
         ir_q   <= ir_d;
         idx2_q <= idx2_d;
         v2_q   <= v2_d;
         y_q    <= y_d;
         idx3_q <= idx3_d;
         v3_q   <= v3_d;
      end
   end

   assign o_valid = v3_q;
   assign o_y_re  = y_q.re;
   assign o_y_im  = y_q.im;
   assign o_idx   = idx3_q;

endmodule
`default_nettype wire

// File: rtl/fft_tw4_mul.sv
`default_nettype none
// ============================================================================
// fft_tw4_mul : frame counter / twiddle ROM addressing + 3-stage x*W pipeline.
// Optional clamping via macro FFT_TW_SAT_EN (wrap when undefined). Rev 1.0
// ============================================================================
module fft_tw4_mul
   import fft_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_first,
   input  logic signed [DW-1:0]   in_re,
   input  logic signed [DW-1:0]   in_im,
   output logic [1:0]             tw_addr,
   input  logic signed [TW_W-1:0] tw_re,
   input  logic signed [TW_W-1:0] tw_im,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [DW-1:0]   out_re,
   output logic signed [DW-1:0]   out_im,
   output logic [1:0]             out_idx
);

   logic       adv, acc;
   logic [1:0] cnt_q, cnt_d;
   cplx_t      x1_q, x1_d;
   tw_t        w1_q, w1_d;
   logic [1:0] idx1_q, idx1_d;
   logic       v1_q, v1_d;

   // One enable for the whole pipe: a stalled output freezes every stage.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign acc      = in_valid && adv;
   assign tw_addr  = in_first ? 2'd0 : cnt_q;

   always_comb begin
      cnt_d  = cnt_q;
      x1_d   = x1_q;
      w1_d   = w1_q;
      idx1_d = idx1_q;
      v1_d   = v1_q;
      if (acc)
         cnt_d = tw_addr + 2'd1;
      if (adv) begin
         x1_d.re = in_re;
         x1_d.im = in_im;
         w1_d.re = tw_re;
         w1_d.im = tw_im;
         idx1_d  = tw_addr;
         v1_d    = acc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         x1_q   <= '0;
         w1_q   <= '0;
         idx1_q <= '0;
         v1_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         x1_q   <= x1_d;
         w1_q   <= w1_d;
         idx1_q <= idx1_d;
         v1_q   <= v1_d;
      end
   end

   fft_cmul u_cmul (
      .clk     (clk),
      .rst     (rst),
      .i_en    (adv),
      .i_valid (v1_q),
      .i_x_re  (x1_q.re),
      .i_x_im  (x1_q.im),
      .i_w_re  (w1_q.re),
      .i_w_im  (w1_q.im),
      .i_idx   (idx1_q),
      .o_valid (out_valid),
      .o_y_re  (out_re),
      .o_y_im  (out_im),
      .o_idx   (out_idx)
   );

endmodule
`default_nettype wire

// File: tb/tb_fft_tw4_mul.sv
`default_nettype none
// ============================================================================
// tb_fft_tw4_mul : directed vector table plus stream/stall/resync/reset runs.
// Rev 1.0
// ============================================================================
module tb_fft_tw4_mul;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, in_first;
   logic signed [8:0] in_re, in_im, out_re, out_im;
   logic [1:0]        tw_addr, out_idx;
   logic signed [9:0] tw_re, tw_im;
   logic              out_valid, out_ready;

   logic signed [9:0] rom_re [4];
   logic signed [9:0] rom_im [4];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int re;
      int im;
      int idx;
   } obs_t;
   obs_t got[$];

   typedef struct {
      int in_re;
      int in_im;
      int tw_re;
      int tw_im;
      int exp_re;
      int exp_im;
   } vec_t;
   vec_t vt[8];

   assign tw_re = rom_re[tw_addr];
   assign tw_im = rom_im[tw_addr];

   always #5 clk = ~clk;

   fft_tw4_mul dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_re     (in_re),
      .in_im     (in_im),
      .tw_addr   (tw_addr),
      .tw_re     (tw_re),
      .tw_im     (tw_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx)
   );

   always @(negedge clk)
      if (!rst && out_valid && out_ready)
         got.push_back('{int'(out_re), int'(out_im), int'(out_idx)});

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_rom(input int r, input int i);
      for (int a = 0; a < 4; a++) begin
         rom_re[a] = 10'(r);
         rom_im[a] = 10'(i);
      end
   endtask

   task automatic send(input int r, input int i, input logic first);
      int tries;
      @(negedge clk);
      in_valid = 1'b1;
      in_re    = 9'(r);
      in_im    = 9'(i);
      in_first = first;
      tries    = 0;
      while (!in_ready && tries < 100) begin
         @(negedge clk);
         tries++;
      end
      if (!in_ready)
         chk("send_ready_timeout", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
   endtask

   task automatic wait_count(input string nm, input int n);
      int c;
      c = 0;
      while (got.size() < n && c < 100) begin
         @(negedge clk);
         c++;
      end
      repeat (4) @(negedge clk);
      chk(nm, got.size(), n);
   endtask

   task automatic chk_obs(input string nm, input int k, input int re, input int im, input int idx);
      if (k < got.size()) begin
         chk($sformatf("%s%0d_re", nm, k), got[k].re, re);
         chk($sformatf("%s%0d_im", nm, k), got[k].im, im);
         chk($sformatf("%s%0d_idx", nm, k), got[k].idx, idx);
      end else begin
         chk($sformatf("%s%0d_present", nm, k), got.size(), k + 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int held;

      vt[0] = '{100, -50, 256, 0, 100, -50};
      vt[1] = '{100, -50, 0, -256, -50, -100};
      vt[2] = '{3, -3, 128, 0, 2, -1};
      vt[3] = '{-3, 3, 128, 0, -1, 2};
`ifdef FFT_TW_SAT_EN
      vt[4] = '{255, 255, 256, -256, 255, 0};
      vt[5] = '{-256, 0, -256, 0, 255, 0};
      vt[6] = '{-256, 255, 256, 256, -256, -1};
`else
      vt[4] = '{255, 255, 256, -256, -2, 0};
      vt[5] = '{-256, 0, -256, 0, -256, 0};
      vt[6] = '{-256, 255, 256, 256, 1, -1};
`endif
      vt[7] = '{-256, 0, 256, 0, -256, 0};

      rst = 1'b1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_re = '0;
      in_im = '0;
      out_ready = 1'b1;
      set_rom(256, 0);
      repeat (2) @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_re", int'(out_re), 0);
      chk("rst_out_im", int'(out_im), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_tw_addr", int'(tw_addr), 0);
      rst = 1'b0;

      // isolated transactions: latency, arithmetic, rounding, saturation
      for (int i = 0; i < 8; i++) begin
         set_rom(vt[i].tw_re, vt[i].tw_im);
         send(vt[i].in_re, vt[i].in_im, i == 0);
         wait_out(lat);
         chk($sformatf("vec%0d_latency", i), lat, 3);
         chk($sformatf("vec%0d_re", i), int'(out_re), vt[i].exp_re);
         chk($sformatf("vec%0d_im", i), int'(out_im), vt[i].exp_im);
         chk($sformatf("vec%0d_idx", i), int'(out_idx), i % 4);
      end
      repeat (3) @(negedge clk);

      // identity twiddle, one full frame back to back
      set_rom(256, 0);
      got.delete();
      for (int k = 0; k < 4; k++)
         send(100, -50, k == 0);
      wait_count("ident_count", 4);
      for (int k = 0; k < 4; k++)
         chk_obs("ident", k, 100, -50, k);

      // backpressure: 8-sample stream with a 5-cycle output stall
      got.delete();
      fork
         begin
            for (int k = 0; k < 8; k++)
               send(10 * k, -k, k == 0);
         end
         begin
            held = 0;
            while (!out_valid && held < 50) begin
               @(negedge clk);
               held++;
            end
            @(posedge clk);
            #2;
            out_ready = 1'b0;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               chk($sformatf("stall%0d_in_ready", j), int'(in_ready), 0);
               chk($sformatf("stall%0d_out_re", j), int'(out_re), 10);
               chk($sformatf("stall%0d_out_idx", j), int'(out_idx), 1);
            end
            @(posedge clk);
            #2;
            out_ready = 1'b1;
         end
      join
      wait_count("bp_count", 8);
      for (int k = 0; k < 8; k++)
         chk_obs("bp", k, 10 * k, -k, k % 4);

      // mid-frame in_first: addressing restarts at 0
      rom_re[0] = 256;  rom_im[0] = 0;
      rom_re[1] = 0;    rom_im[1] = -256;
      rom_re[2] = 128;  rom_im[2] = 0;
      rom_re[3] = -256; rom_im[3] = 0;
      got.delete();
      send(100, -50, 1'b1);
      send(100, -50, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
      #1;
      chk("resync_tw_addr_cnt", int'(tw_addr), 2);
      in_first = 1'b1;
      #1;
      chk("resync_tw_addr_first", int'(tw_addr), 0);
      send(100, -50, 1'b1);
      send(100, -50, 1'b0);
      wait_count("resync_count", 4);
      chk_obs("resync", 0, 100, -50, 0);
      chk_obs("resync", 1, -50, -100, 1);
      chk_obs("resync", 2, 100, -50, 0);
      chk_obs("resync", 3, -50, -100, 1);

      // asynchronous reset with samples in flight
      set_rom(256, 0);
      send(20, -20, 1'b1);
      send(30, -30, 1'b0);
      send(35, -35, 1'b0);
      #2;
      chk("prerst_out_valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", int'(out_valid), 0);
      chk("async_rst_out_re", int'(out_re), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      got.delete();
      send(40, -40, 1'b0);
      wait_count("postrst_count", 1);
      chk_obs("postrst", 0, 40, -40, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
